mcpu_alu_operand_stage: RTL and testbench

//  Upstream operand/issue stage for the MCPU_Alu combinational ALU. Holds a small register file
//  and accepts one instruction at a time (opcode, rd, rs1, rs2) via a valid/ready handshake.

---
 rtl/mcpu_alu_operand_stage.sv | 141 ++++++++++++++
 tb/tb_mcpu_alu_operand_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_alu_operand_stage.sv
// mcpu_alu_operand_stage
// Operand/issue stage in front of the MCPU_Alu combinational ALU. It holds a
// small register file and takes one instruction at a time over a valid/ready
// handshake. It sequences IDLE -> READ -> EXEC -> WB and then returns to IDLE.
// In READ it drives the ALU operands from the register file. In EXEC it
// captures the ALU result. In WB it writes the result back to rd and pulses done.
// Optional build macro: MCPU_HIGH_WB_EN. When it is defined, WB also writes the
// upper half of the result to register (rd+1) mod REG_COUNT.
module mcpu_alu_operand_stage #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [CMD_SIZE-1:0]    instr_opcode,
  input  logic [ADDR_SIZE-1:0]   instr_rd,
  input  logic [ADDR_SIZE-1:0]   instr_rs1,
  input  logic [ADDR_SIZE-1:0]   instr_rs2,
  input  logic                   load_en,
  input  logic [ADDR_SIZE-1:0]   load_addr,
  input  logic [WORD_SIZE-1:0]   load_data,
  output logic [CMD_SIZE-1:0]    alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_r1,
  output logic [WORD_SIZE-1:0]   alu_r2,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  input  logic                   alu_overflow,
  output logic                   done,
  output logic [2*WORD_SIZE-1:0] result,
  output logic                   ovf_flag,
  input  logic                   ovf_clr,
  input  logic [ADDR_SIZE-1:0]   dbg_addr,
  output logic [WORD_SIZE-1:0]   dbg_data
);

  localparam int REG_COUNT = 2**ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t                 state;
  logic [CMD_SIZE-1:0]    op_q;
  logic [ADDR_SIZE-1:0]   rd_q;
  logic [ADDR_SIZE-1:0]   rs1_q;
  logic [ADDR_SIZE-1:0]   rs2_q;
  logic                   ovf_pending;
  logic [WORD_SIZE-1:0]   regfile [REG_COUNT];

  assign instr_ready = (state == IDLE);
  assign dbg_data    = regfile[dbg_addr];

`ifdef MCPU_HIGH_WB_EN
  logic [ADDR_SIZE-1:0] rd_hi;
  assign rd_hi = rd_q + ADDR_SIZE'(1);
`endif

  // Instruction sequencer: latch the instruction, drive the ALU, capture the result, and pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_opcode  <= '0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      result      <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_opcode;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            state <= READ;
          end
        end
        READ: begin
          alu_opcode <= op_q;
          alu_r1     <= regfile[rs1_q];
          alu_r2     <= regfile[rs2_q];
          state      <= EXEC;
        end
        EXEC: begin
          result      <= alu_out;
          ovf_pending <= alu_overflow;
          done        <= 1'b1;
          state       <= WB;
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register file: preload port in every state, write-back issued later so it wins on the same address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regfile[i] <= '0;
      end
    end else begin
      if (load_en) begin
        regfile[load_addr] <= load_data;
      end
      if (state == WB) begin
        regfile[rd_q] <= result[WORD_SIZE-1:0];
`ifdef MCPU_HIGH_WB_EN
        regfile[rd_hi] <= result[2*WORD_SIZE-1:WORD_SIZE];
`endif
      end
    end
  end

  // Sticky overflow: a write-back with overflow takes priority over a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if ((state == WB) && ovf_pending) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcpu_alu_operand_stage.sv
// tb_mcpu_alu_operand_stage
// Bench for the operand stage. It drives a small behavioural stand-in for
// MCPU_Alu. The stand-in computes AND, OR and XOR zero-extended. ADD produces a
// 9-bit sum, and its carry is reported as overflow. Directed instructions push
// their hand-computed results into a scoreboard. A monitor pops an entry on
// every done pulse and checks both the result and the cycle in which done arrives.
module tb_mcpu_alu_operand_stage;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_opcode;
  logic [1:0]  instr_rd;
  logic [1:0]  instr_rs1;
  logic [1:0]  instr_rs2;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [7:0]  load_data;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_r1;
  logic [7:0]  alu_r2;
  logic [15:0] alu_out;
  logic        alu_overflow;
  logic        done;
  logic [15:0] result;
  logic        ovf_flag;
  logic        ovf_clr;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [8:0] sum9;

  mcpu_alu_operand_stage #(.CMD_SIZE(2), .WORD_SIZE(8), .ADDR_SIZE(2)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .done(done), .result(result), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time done pulses relative to the accept edge
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU stand-in
  always_comb begin
    sum9         = {1'b0, alu_r1} + {1'b0, alu_r2};
    alu_overflow = 1'b0;
    case (alu_opcode)
      2'b00:   alu_out = {8'h00, alu_r1 & alu_r2};
      2'b01:   alu_out = {8'h00, alu_r1 | alu_r2};
      2'b10:   alu_out = {8'h00, alu_r1 ^ alu_r2};
      default: begin
        alu_out      = {7'h00, sum9};
        alu_overflow = sum9[8];
      end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected write-back, including its cycle
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 required done=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("wb_result", {16'h0, result}, {16'h0, mon_e.res});
        checkOutput("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Accepted at edge A (cyc==A just after it): READ, EXEC, then WB visible after edge A+2
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                               input logic [1:0] rs2, input logic [15:0] exp_res, input bit push);
    bit got;
    got          = 1'b0;
    instr_opcode = op;
    instr_rd     = rd;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    instr_valid  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got instr_ready=0 required 1 within 20 cycles");
    end else if (push) begin
      sb.push_back('{exp_res, cyc + 2});
    end
  endtask

  task automatic loadReg(input logic [1:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic checkReg(input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    @(negedge clk);
    checkOutput($sformatf("reg%0d", addr), {24'h0, dbg_data}, {24'h0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (sb.size() == 0 && instr_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; load_en = 1'b0; load_addr = '0;
    load_data = '0; ovf_clr = 1'b0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_ready", {31'h0, instr_ready}, 32'h1);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_result", {16'h0, result}, 32'h0);
    checkOutput("rst_ovf", {31'h0, ovf_flag}, 32'h0);
    for (int a = 0; a < 4; a++) checkReg(2'(a), 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD 0F + 3C -> 004B into R3
    loadReg(2'd1, 8'h0F);
    loadReg(2'd2, 8'h3C);
    applyStimulus(2'b11, 2'd3, 2'd1, 2'd2, 16'h004B, 1'b1);
    waitIdle();
    checkReg(2'd3, 8'h4B);
    checkOutput("hold_opcode", {30'h0, alu_opcode}, 32'h3);
    checkOutput("hold_r1", {24'h0, alu_r1}, 32'h0F);
    checkOutput("hold_r2", {24'h0, alu_r2}, 32'h3C);
    checkOutput("ovf_none", {31'h0, ovf_flag}, 32'h0);

    // ADD FF + 01 -> 0100, low half into R2, overflow set
    loadReg(2'd0, 8'hFF);
    loadReg(2'd1, 8'h01);
    applyStimulus(2'b11, 2'd2, 2'd0, 2'd1, 16'h0100, 1'b1);
    waitIdle();
    checkReg(2'd2, 8'h00);
`ifdef MCPU_HIGH_WB_EN
    checkReg(2'd3, 8'h01);
`else
    checkReg(2'd3, 8'h4B);
`endif
    checkOutput("ovf_set", {31'h0, ovf_flag}, 32'h1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("ovf_clr", {31'h0, ovf_flag}, 32'h0);

    // XOR with instr_valid held high: ready low for 3 cycles, re-accept only from IDLE
    instr_opcode = 2'b10; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
    instr_valid  = 1'b1;
    @(negedge clk);
    checkOutput("xor_ready_idle", {31'h0, instr_ready}, 32'h1);
    @(posedge clk);
    #1;
    sb.push_back('{16'h00FE, cyc + 2});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("busy_ready", {31'h0, instr_ready}, 32'h0);
    end
    @(negedge clk);
    checkOutput("xor_ready_again", {31'h0, instr_ready}, 32'h1);
    @(posedge clk);
    #1;
    sb.push_back('{16'h00FE, cyc + 2});
    instr_valid = 1'b0;
    waitIdle();
    checkReg(2'd2, 8'hFE);

    // OR with a same-address load in the WB cycle: write-back wins
    applyStimulus(2'b01, 2'd1, 2'd0, 2'd2, 16'h00FF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    loadReg(2'd1, 8'hAA);
    waitIdle();
    checkReg(2'd1, 8'hFF);
`ifdef MCPU_HIGH_WB_EN
    checkReg(2'd2, 8'h00);
`else
    checkReg(2'd2, 8'hFE);
`endif

    // AND with rd==rs2
    loadReg(2'd2, 8'h5A);
    loadReg(2'd3, 8'h3C);
    applyStimulus(2'b00, 2'd3, 2'd2, 2'd3, 16'h0018, 1'b1);
    waitIdle();
    checkReg(2'd3, 8'h18);

    // Load to rs1/rs2 during READ is not seen by that instruction: 18+18=30
    applyStimulus(2'b11, 2'd1, 2'd3, 2'd3, 16'h0030, 1'b1);
    loadReg(2'd3, 8'h77);
    waitIdle();
    checkReg(2'd1, 8'h30);
    checkReg(2'd3, 8'h77);

    // Reset in EXEC aborts: no done pulse, everything cleared
    applyStimulus(2'b11, 2'd0, 2'd1, 2'd1, 16'h0060, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_ready", {31'h0, instr_ready}, 32'h1);
    checkOutput("abort_done", {31'h0, done}, 32'h0);
    checkOutput("abort_result", {16'h0, result}, 32'h0);
    checkOutput("abort_alu_r1", {24'h0, alu_r1}, 32'h0);
    for (int a = 0; a < 4; a++) checkReg(2'(a), 8'h00);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Overflow set and ovf_clr in the same cycle: set wins
    loadReg(2'd0, 8'hFF);
    loadReg(2'd1, 8'h01);
    applyStimulus(2'b11, 2'd2, 2'd0, 2'd1, 16'h0100, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("ovf_set_wins", {31'h0, ovf_flag}, 32'h1);
    waitIdle();

    checkOutput("sb_drain", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
